// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry path: scancodes, key classes,
// FSM state encoding and ALU opcode encoding.
package calc_pkg;

   localparam int unsigned SC_W = 9;

   localparam logic [SC_W-1:0] SC_0     = 9'h070;
   localparam logic [SC_W-1:0] SC_1     = 9'h069;
   localparam logic [SC_W-1:0] SC_2     = 9'h072;
   localparam logic [SC_W-1:0] SC_3     = 9'h07A;
   localparam logic [SC_W-1:0] SC_4     = 9'h06B;
   localparam logic [SC_W-1:0] SC_5     = 9'h073;
   localparam logic [SC_W-1:0] SC_6     = 9'h074;
   localparam logic [SC_W-1:0] SC_7     = 9'h06C;
   localparam logic [SC_W-1:0] SC_8     = 9'h075;
   localparam logic [SC_W-1:0] SC_9     = 9'h07D;
   localparam logic [SC_W-1:0] SC_ADD   = 9'h079;
   localparam logic [SC_W-1:0] SC_SUB   = 9'h07B;
   localparam logic [SC_W-1:0] SC_MUL   = 9'h07C;
   localparam logic [SC_W-1:0] SC_ENTER = 9'h05A;
   localparam logic [SC_W-1:0] SC_BKSP  = 9'h066;
   localparam logic [SC_W-1:0] SC_ESC   = 9'h076;

   typedef enum logic [2:0] {
      KEY_OTHER = 3'd0,
      KEY_DIGIT = 3'd1,
      KEY_OP    = 3'd2,
      KEY_ENTER = 3'd3,
      KEY_BKSP  = 3'd4,
      KEY_ESC   = 3'd5
   } key_class_t;

   typedef enum logic [1:0] {
      ST_FIRST  = 2'd0,
      ST_OPER   = 2'd1,
      ST_SECOND = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OPC_ADD = 2'd0,
      OPC_SUB = 2'd1,
      OPC_MUL = 2'd2
   } opcode_t;

endpackage

// File: rtl/calc_key_decode.sv
// Combinational scancode classifier: key class, digit value and operator.
module calc_key_decode
   import calc_pkg::*;
(
   input  logic [SC_W-1:0] scancode_i,
   output key_class_t      class_o,
   output logic [3:0]      digit_o,
   output opcode_t         op_o
);

   always_comb begin
      class_o = KEY_OTHER;
      digit_o = 4'd0;
      op_o    = OPC_ADD;
      case (scancode_i)
         SC_0:     begin class_o = KEY_DIGIT; digit_o = 4'd0; end
         SC_1:     begin class_o = KEY_DIGIT; digit_o = 4'd1; end
         SC_2:     begin class_o = KEY_DIGIT; digit_o = 4'd2; end
         SC_3:     begin class_o = KEY_DIGIT; digit_o = 4'd3; end
         SC_4:     begin class_o = KEY_DIGIT; digit_o = 4'd4; end
         SC_5:     begin class_o = KEY_DIGIT; digit_o = 4'd5; end
         SC_6:     begin class_o = KEY_DIGIT; digit_o = 4'd6; end
         SC_7:     begin class_o = KEY_DIGIT; digit_o = 4'd7; end
         SC_8:     begin class_o = KEY_DIGIT; digit_o = 4'd8; end
         SC_9:     begin class_o = KEY_DIGIT; digit_o = 4'd9; end
         SC_ADD:   begin class_o = KEY_OP;    op_o = OPC_ADD; end
         SC_SUB:   begin class_o = KEY_OP;    op_o = OPC_SUB; end
         SC_MUL:   begin class_o = KEY_OP;    op_o = OPC_MUL; end
         SC_ENTER: class_o = KEY_ENTER;
         SC_BKSP:  class_o = KEY_BKSP;
         SC_ESC:   class_o = KEY_ESC;
         default:  ;
      endcase
   end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keyboard entry FSM for a two-operand calculator: builds decimal operands,
// latches the operator, triggers the ALU and supports result chaining.
module calc_entry_fsm
   import calc_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 4,
   parameter int unsigned OPW        = 14
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [8:0]                        last_change,
   input  logic                              key_down_onepulse,
   input  logic [OPW-1:0]                    result,
   output logic [OPW-1:0]                    op_a,
   output logic [OPW-1:0]                    op_b,
   output logic [1:0]                        opcode,
   output logic [1:0]                        state,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
   output logic                              start_calc,
   output logic                              clear_pulse
);

   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

   key_class_t     key_class;
   logic [3:0]     key_digit;
   opcode_t        key_op;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   opcode_t        opcode_q, opcode_d;
   logic [CW-1:0]  cnt_q, cnt_d, a_cnt_q, a_cnt_d;
   logic           start_q, start_d, clear_q, clear_d;

   calc_key_decode u_decode (
      .scancode_i (last_change),
      .class_o    (key_class),
      .digit_o    (key_digit),
      .op_o       (key_op)
   );

   // Decimal digit count of a chained result, saturated at MAX_DIGITS so that
   // further digit entry on it is refused while backspace still trims it.
   function automatic logic [CW-1:0] dec_digits(input logic [OPW-1:0] v);
      int unsigned n;
      int unsigned thr;
      n   = 1;
      thr = 10;
      for (int unsigned k = 1; k < MAX_DIGITS; k++) begin
         if (32'(v) >= thr) n = k + 1;
         thr = thr * 10;
      end
      return CW'(n);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FIRST;
         op_a_q   <= '0;
         op_b_q   <= '0;
         opcode_q <= OPC_ADD;
         cnt_q    <= '0;
         a_cnt_q  <= '0;
         start_q  <= 1'b0;
         clear_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         opcode_q <= opcode_d;
         cnt_q    <= cnt_d;
         a_cnt_q  <= a_cnt_d;
         start_q  <= start_d;
         clear_q  <= clear_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      opcode_d = opcode_q;
      cnt_d    = cnt_q;
      a_cnt_d  = a_cnt_q;
      start_d  = 1'b0;
      clear_d  = 1'b0;
      if (key_down_onepulse) begin
         if (key_class == KEY_ESC) begin
            state_d  = ST_FIRST;
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = OPC_ADD;
            cnt_d    = '0;
            a_cnt_d  = '0;
            clear_d  = 1'b1;
         end else begin
            case (state_q)
               ST_FIRST: begin
                  case (key_class)
                     KEY_DIGIT: if (cnt_q < CW'(MAX_DIGITS)) begin
                        op_a_d = OPW'(op_a_q * OPW'(10) + OPW'(key_digit));
                        cnt_d  = cnt_q + CW'(1);
                     end
                     KEY_BKSP: if (cnt_q != '0) begin
                        op_a_d = op_a_q / OPW'(10);
                        cnt_d  = cnt_q - CW'(1);
                     end
                     KEY_OP: if (cnt_q != '0) begin
                        opcode_d = key_op;
                        a_cnt_d  = cnt_q;
                        cnt_d    = '0;
                        state_d  = ST_OPER;
                     end
                     default: ;
                  endcase
               end
               ST_OPER: begin
                  case (key_class)
                     KEY_OP: opcode_d = key_op;
                     KEY_DIGIT: begin
                        op_b_d  = OPW'(key_digit);
                        cnt_d   = CW'(1);
                        state_d = ST_SECOND;
                     end
                     KEY_BKSP: begin
                        cnt_d   = a_cnt_q;
                        state_d = ST_FIRST;
                     end
                     default: ;
                  endcase
               end
               ST_SECOND: begin
                  case (key_class)
                     KEY_DIGIT: if (cnt_q < CW'(MAX_DIGITS)) begin
                        op_b_d = OPW'(op_b_q * OPW'(10) + OPW'(key_digit));
                        cnt_d  = cnt_q + CW'(1);
                     end
                     KEY_BKSP: begin
                        if (cnt_q != '0) begin
                           op_b_d = op_b_q / OPW'(10);
                           cnt_d  = cnt_q - CW'(1);
                        end else begin
                           state_d = ST_OPER;
                        end
                     end
                     KEY_ENTER: if (cnt_q != '0) begin
                        start_d = 1'b1;
                        state_d = ST_RESULT;
                     end
                     default: ;
                  endcase
               end
               ST_RESULT: begin
                  case (key_class)
                     KEY_DIGIT: begin
                        op_a_d   = OPW'(key_digit);
                        op_b_d   = '0;
                        opcode_d = OPC_ADD;
                        cnt_d    = CW'(1);
                        clear_d  = 1'b1;
                        state_d  = ST_FIRST;
                     end
                     KEY_OP: begin
                        op_a_d   = result;
                        op_b_d   = '0;
                        opcode_d = key_op;
                        a_cnt_d  = dec_digits(result);
                        cnt_d    = '0;
                        state_d  = ST_OPER;
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign opcode      = opcode_q;
   assign state       = state_q;
   assign digit_cnt   = cnt_q;
   assign start_calc  = start_q;
   assign clear_pulse = clear_q;

endmodule

// File: doc/calc_entry_fsm.md
CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 The module SHALL have parameter MAX_DIGITS, default 4, the maximum decimal digits accepted per operand.
REQ-002 The module SHALL have parameter OPW, default 14, the operand width in bits; OPW SHALL be at least ceil(log2(10^MAX_DIGITS)).
REQ-003 The module SHALL have port clk, input, 1 bit: system clock, all state changes on rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port last_change, input, 9 bits: scancode of the most recent key.
REQ-006 The module SHALL have port key_down_onepulse, input, 1 bit: one-cycle strobe that qualifies last_change.
REQ-007 The module SHALL have port result, input, OPW bits: ALU result, used for operator chaining.
REQ-008 The module SHALL have ports op_a and op_b, output, OPW bits each: binary value of operand A and operand B.
REQ-009 The module SHALL have port opcode, output, 2 bits: 0 add, 1 sub, 2 mul.
REQ-010 The module SHALL have port state, output, 2 bits: current FSM state.
REQ-011 The module SHALL have port digit_cnt, output, $clog2(MAX_DIGITS+1) bits: digits held in the active operand.
REQ-012 The module SHALL have ports start_calc and clear_pulse, output, 1 bit each: one-cycle strobes.

Function
REQ-013 A key event SHALL exist only in a cycle where key_down_onepulse=1; last_change SHALL be ignored otherwise.
REQ-014 The module SHALL decode last_change into six key classes:
- DIGIT: 0x070=0, 0x069=1, 0x072=2, 0x07A=3, 0x06B=4, 0x073=5, 0x074=6, 0x06C=7, 0x075=8, 0x07D=9.
- OP: 0x079 add, 0x07B sub, 0x07C mul.
- ENTER: 0x05A.
- BKSP: 0x066.
- ESC: 0x076.
- OTHER: any other scancode; the event SHALL be ignored.
REQ-015 The FSM SHALL have states FIRST=0, OPER=1, SECOND=2, RESULT=3.
REQ-016 In FIRST and SECOND, DIGIT with digit_cnt<MAX_DIGITS SHALL update the active operand to operand*10+digit and increment digit_cnt.
REQ-017 DIGIT with digit_cnt==MAX_DIGITS SHALL be ignored, with no state or value change.
REQ-018 Leading zeros SHALL count as digits.
REQ-019 BKSP in FIRST or SECOND with digit_cnt>0 SHALL set the active operand to operand/10 (truncating) and decrement digit_cnt; BKSP with digit_cnt==0 in FIRST SHALL be ignored.
REQ-020 FIRST: OP with digit_cnt>0 SHALL latch opcode and go to OPER; OP with digit_cnt==0 SHALL be ignored; ENTER SHALL be ignored.
REQ-021 OPER:
- OP SHALL overwrite opcode and stay in OPER.
- DIGIT SHALL load op_b=digit, set digit_cnt=1 and go to SECOND.
- BKSP SHALL return to FIRST, restoring digit_cnt to the digit count of op_a.
- ENTER SHALL be ignored.
REQ-022 SECOND:
- ENTER with digit_cnt>0 SHALL go to RESULT and assert start_calc for exactly one cycle.
- ENTER with digit_cnt==0 SHALL be ignored.
- BKSP with digit_cnt==0 SHALL return to OPER.
- OP SHALL be ignored.
REQ-023 RESULT:
- DIGIT SHALL clear op_a, op_b and opcode, pulse clear_pulse, load op_a=digit, set digit_cnt=1 and go to FIRST.
- OP SHALL load op_a=result[OPW-1:0], clear op_b, latch opcode and go to OPER (chaining).
- ENTER and BKSP SHALL be ignored.
REQ-024 ESC in any state SHALL force FIRST, zero op_a, op_b, opcode and digit_cnt, and pulse clear_pulse.
REQ-025 All outputs SHALL be registered and SHALL reflect an event at the clock edge on which key_down_onepulse is sampled high.
REQ-026 start_calc SHALL be high in the cycle following that edge, for one cycle only.
REQ-027 Operand arithmetic SHALL be unsigned and SHALL never overflow OPW, which is guaranteed by REQ-002 and REQ-017.

Reset
REQ-028 Asserting rst SHALL immediately set state=FIRST and op_a=op_b=0, opcode=0, digit_cnt=0, start_calc=0, clear_pulse=0, including in the middle of operand entry.
REQ-029 The first key event after rst deassertion SHALL be processed normally.

Structure
REQ-030 A shared package calc_pkg SHALL hold the scancode constants, the key-class enumeration, the state encoding and the opcode encoding.
REQ-031 Scancode classification SHALL be a combinational sub-module calc_key_decode with outputs key class and digit value (4 bits).
REQ-032 The op_a digit count SHALL be retained internally so that REQ-021 BKSP restores it.

Verification
REQ-033 Sequence rst, "1","2","3","+","4","5",ENTER -> op_a=123, opcode=0, op_b=45, state=RESULT, start_calc high for exactly one cycle.
REQ-034 Digits "9","9","9","9","9" -> op_a=9999, digit_cnt=4 (fifth digit ignored); then BKSP -> op_a=999, digit_cnt=3.
REQ-035 "+" in FIRST with digit_cnt=0, and ENTER in SECOND before any digit -> both ignored, state unchanged.
REQ-036 "7","*","6",ENTER, with result driven to 42, then "-" -> op_a=42, opcode=1, op_b=0, state=OPER; then "2",ENTER -> start_calc pulse.
REQ-037 "5","+","3" then ESC -> state=FIRST, all outputs zero, clear_pulse high for one cycle.
REQ-038 rst asserted asynchronously mid-entry ("1","2") -> all outputs reach reset values before the next clk edge.
